// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Elastic pipeline-stage register built as a 2-entry skid buffer. It carries a
//   DATA_W-bit packed stage bundle with valid/ready handshaking on both sides.
//   in_ready comes from registered state only, so there is no combinational path
//   from out_ready back to in_ready. A synchronous flush squashes the stage into
//   an all-zero bubble. Two saturating event counters count stalls and flushes.
//
// Ports
//   CLK        clock
//   nRST       asynchronous active-low reset
//   in_valid   upstream bundle valid
//   in_ready   stage can accept (decoded from registered state)
//   in_data    upstream bundle
//   out_valid  head bundle valid
//   out_ready  downstream accepts head
//   out_data   head bundle, all zeros while out_valid=0
//   flush      synchronous squash of all held and incoming data
//   cnt_clr    synchronous clear of both counters (wins over increment)
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
//   flush_cnt  cycles with flush=1, saturating
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic in_fire_s;
  logic out_fire_s;
  logic stall_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // Output decode from registered state only.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
    out_data  = main_q;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign stall_s    = out_valid & ~out_ready;

  // Next-state for the buffer; flush overrides every handshake and zeroes both entries.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = DATA_ZERO;
      skid_d  = DATA_ZERO;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire_s) begin
            state_d = ONE;
            main_d  = in_data;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_d = ONE;
            main_d  = in_data;
          end else if (in_fire_s) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire_s) begin
            // Zero the head on drain so a bubble reads as a NOP.
            state_d = EMPTY;
            main_d  = DATA_ZERO;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = DATA_ZERO;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = DATA_ZERO;
          skid_d  = DATA_ZERO;
        end
      endcase
    end
  end

  // Next-state for the event counters; clear beats increment, flush leaves them alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = CNT_ZERO;
      flush_cnt_d = CNT_ZERO;
    end else begin
      if (stall_s) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (flush) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State, data and counter registers with asynchronous reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_q      <= DATA_ZERO;
      skid_q      <= DATA_ZERO;
      stall_cnt_q <= CNT_ZERO;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              CLK;
  logic              nRST;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              cnt_clr;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir,
                           input logic [31:0] od, input logic [1:0] occ);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    chk({tag, "_out_data"},  out_data,           od);
    chk({tag, "_occ"},       {30'd0, occupancy}, {30'd0, occ});
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0;
    #2;
    chk_state("reset", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("reset_stall", {30'd0, stall_cnt}, 32'd0);
    chk("reset_flush", {30'd0, flush_cnt}, 32'd0);
    #10 nRST = 1'b1;
    tick();

    // Streaming at full throughput
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
    tick();
    chk_state("s11", 1'b1, 1'b1, 32'h11, 2'd1);
    in_data = 32'h22;
    tick();
    chk_state("s22", 1'b1, 1'b1, 32'h22, 2'd1);
    in_data = 32'h33;
    tick();
    chk_state("s33", 1'b1, 1'b1, 32'h33, 2'd1);
    in_valid = 1'b0; in_data = 32'h0;
    tick();
    chk_state("s_end", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("s_stall", {30'd0, stall_cnt}, 32'd0);

    // Back-pressure fill
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
    tick();
    chk_state("bp1", 1'b1, 1'b1, 32'hA1, 2'd1);
    chk("bp1_stall", {30'd0, stall_cnt}, 32'd0);
    in_data = 32'hA2;
    tick();
    chk_state("bp2", 1'b1, 1'b0, 32'hA1, 2'd2);
    chk("bp2_stall", {30'd0, stall_cnt}, 32'd1);
    in_data = 32'hA3;
    tick();
    chk_state("bp3", 1'b1, 1'b0, 32'hA1, 2'd2);
    chk("bp3_stall", {30'd0, stall_cnt}, 32'd2);
    tick();
    chk("bp4_stall", {30'd0, stall_cnt}, 32'd3);

    // Drain from full; A3 was never accepted
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
    tick();
    chk_state("dr1", 1'b1, 1'b1, 32'hA2, 2'd1);
    chk("dr1_stall", {30'd0, stall_cnt}, 32'd3);
    tick();
    chk_state("dr2", 1'b0, 1'b1, 32'h0, 2'd0);
    tick();
    chk_state("dr3", 1'b0, 1'b1, 32'h0, 2'd0);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_stall", {30'd0, stall_cnt}, 32'd0);

    // Flush with simultaneous input
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hB1;
    tick();
    in_data = 32'hB2;
    tick();
    chk_state("fl_full", 1'b1, 1'b0, 32'hB1, 2'd2);
    in_data = 32'hB3; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    chk_state("fl1", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("fl1_flush_cnt", {30'd0, flush_cnt}, 32'd1);
    chk("fl1_stall", {30'd0, stall_cnt}, 32'd2);
    tick();
    chk_state("fl2", 1'b0, 1'b1, 32'h0, 2'd0);

    // Counter saturation and clear-over-increment
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat_clr_flush", {30'd0, flush_cnt}, 32'd0);
    in_valid = 1'b1; in_data = 32'hC1;
    tick();
    in_valid = 1'b0; in_data = 32'h0;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_stall", {30'd0, stall_cnt}, 32'd3);
    chk_state("sat_hold", 1'b1, 1'b1, 32'hC1, 2'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat_clr_stall", {30'd0, stall_cnt}, 32'd0);

    // Async reset while full
    in_valid = 1'b1; in_data = 32'hD1;
    tick();
    in_valid = 1'b0; in_data = 32'h0;
    chk_state("ar_full", 1'b1, 1'b0, 32'hC1, 2'd2);
    chk("ar_stall_pre", {30'd0, stall_cnt}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk_state("ar", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("ar_stall", {30'd0, stall_cnt}, 32'd0);
    chk("ar_flush", {30'd0, flush_cnt}, 32'd0);
    #3 nRST = 1'b1;
    tick();
    chk_state("ar_post", 1'b0, 1'b1, 32'h0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
